// File: rtl/cordic_pkg.sv
// rtl/cordic_pkg.sv - shared constants and types for the iterative vectoring CORDIC
//
// Purpose : arctangent table, quadrant angles, inverse gain and FSM state type
//           shared by cordic_vector_iter and cordic_vec_step.
// Angles  : binary angle units, 2^32 = 360 degrees.
// Ports   : none (package).
package cordic_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_ITER  = 2'd1,
    ST_SCALE = 2'd2,
    ST_DONE  = 2'd3
  } state_e;

  localparam logic [31:0] ANGLE_90     = 32'h4000_0000;
  localparam logic [31:0] ANGLE_M90    = 32'hC000_0000;
  // 1/K in Q1.15, K being the accumulated micro-rotation gain (~1.6468)
  localparam logic [15:0] INV_GAIN_Q15 = 16'd19898;

  // round(atan(2^-i) * 2^32 / (2*pi))
  localparam logic [31:0] ATAN_LUT [0:31] = '{
    32'h2000_0000, 32'h12E4_051E, 32'h09FB_385B, 32'h0511_11D4,
    32'h028B_0D43, 32'h0145_D7E1, 32'h00A2_F61E, 32'h0051_7C55,
    32'h0028_BE53, 32'h0014_5F2F, 32'h000A_2F98, 32'h0005_17CC,
    32'h0002_8BE6, 32'h0001_45F3, 32'h0000_A2FA, 32'h0000_517D,
    32'h0000_28BE, 32'h0000_145F, 32'h0000_0A30, 32'h0000_0518,
    32'h0000_028C, 32'h0000_0146, 32'h0000_00A3, 32'h0000_0051,
    32'h0000_0029, 32'h0000_0014, 32'h0000_000A, 32'h0000_0005,
    32'h0000_0003, 32'h0000_0001, 32'h0000_0001, 32'h0000_0000
  };

endpackage

// File: rtl/cordic_vec_step.sv
// rtl/cordic_vec_step.sv - one combinational vectoring micro-rotation
//
// Purpose : rotates (x,y) towards the positive x axis by atan(2^-shift),
//           accumulating the rotated angle into z.
// Ports   : x_i, y_i  signed working-width vector before the step
//           z_i       accumulated angle before the step
//           shift_i   micro-rotation index i
//           x_o, y_o  vector after the step
//           z_o       accumulated angle after the step (wraps mod 2^32)
module cordic_vec_step
  import cordic_pkg::*;
#(
  parameter int XW = 18
) (
  input  logic signed [XW-1:0] x_i,
  input  logic signed [XW-1:0] y_i,
  input  logic        [31:0]   z_i,
  input  logic        [4:0]    shift_i,
  output logic signed [XW-1:0] x_o,
  output logic signed [XW-1:0] y_o,
  output logic        [31:0]   z_o
);

  logic signed [XW-1:0] x_sh;
  logic signed [XW-1:0] y_sh;
  logic        [31:0]   atan_i;

  assign x_sh   = x_i >>> shift_i;
  assign y_sh   = y_i >>> shift_i;
  assign atan_i = ATAN_LUT[shift_i];

  // Both updates use the pre-step x and y.
  always_comb begin
    if (!y_i[XW-1]) begin
      x_o = x_i + y_sh;
      y_o = y_i - x_sh;
      z_o = z_i + atan_i;
    end else begin
      x_o = x_i - y_sh;
      y_o = y_i + x_sh;
      z_o = z_i - atan_i;
    end
  end

endmodule

// File: rtl/cordic_vector_iter.sv
// rtl/cordic_vector_iter.sv - iterative vectoring CORDIC, one micro-rotation per clock
//
// Purpose : converts a Cartesian vector (x,y) into magnitude and angle atan2(y,x).
// Macro   : CORDIC_GAIN_COMP_EN adds a one-cycle SCALE state multiplying the
//           magnitude by 1/K; without it mag_o carries the CORDIC gain K.
// Ports   : aclk, aresetn      clock, asynchronous active-low reset
//           s_valid, s_ready   input vector handshake
//           x_i, y_i           signed input vector
//           m_valid, m_ready   result handshake
//           mag_o              unsigned magnitude, DATA_WIDTH+1 bits
//           z_o                angle, 2^32 = 360 degrees
module cordic_vector_iter
  import cordic_pkg::*;
#(
  parameter int DATA_WIDTH    = 16,
  parameter int ITERATION_CNT = 16
) (
  input  logic                  aclk,
  input  logic                  aresetn,
  input  logic                  s_valid,
  output logic                  s_ready,
  input  logic [DATA_WIDTH-1:0] x_i,
  input  logic [DATA_WIDTH-1:0] y_i,
  output logic                  m_valid,
  input  logic                  m_ready,
  output logic [DATA_WIDTH:0]   mag_o,
  output logic [31:0]           z_o
);

  // Two guard bits: one so -2^(W-1) can be negated, one for the gain growth.
  localparam int         XW        = DATA_WIDTH + 2;
  localparam logic [4:0] LAST_STEP = 5'(ITERATION_CNT - 1);

  state_e               state_q, state_d;
  logic signed [XW-1:0] x_q, x_d;
  logic signed [XW-1:0] y_q, y_d;
  logic        [31:0]   z_q, z_d;
  logic        [4:0]    cnt_q, cnt_d;
  logic                 zero_q, zero_d;
  logic [DATA_WIDTH:0]  mag_q, mag_d;
  logic        [31:0]   ang_q, ang_d;

  logic signed [XW-1:0] x_ext, y_ext;
  logic signed [XW-1:0] x_step, y_step;
  logic        [31:0]   z_step;
  logic [DATA_WIDTH:0]  mag_src;
  logic        [31:0]   ang_src;
  logic                 last_iter;
  logic                 load_result;

  assign x_ext = {{2{x_i[DATA_WIDTH-1]}}, x_i};
  assign y_ext = {{2{y_i[DATA_WIDTH-1]}}, y_i};

  cordic_vec_step #(.XW(XW)) u_step (
    .x_i    (x_q),
    .y_i    (y_q),
    .z_i    (z_q),
    .shift_i(cnt_q),
    .x_o    (x_step),
    .y_o    (y_step),
    .z_o    (z_step)
  );

`ifdef CORDIC_GAIN_COMP_EN
  localparam logic signed [XW+15:0] INV_GAIN_W = (XW+16)'(INV_GAIN_Q15);
  localparam logic signed [XW+15:0] ROUND_HALF = (XW+16)'(16384);

  logic signed [XW+15:0] x_wide;

  // Result is taken in SCALE, where x_q already holds the final x.
  assign x_wide  = {{16{x_q[XW-1]}}, x_q};
  assign mag_src = (DATA_WIDTH+1)'((x_wide * INV_GAIN_W + ROUND_HALF) >>> 15);
  assign ang_src = z_q;
`else
  // Result is taken straight from the last micro-rotation.
  assign mag_src = x_step[DATA_WIDTH:0];
  assign ang_src = z_step;
`endif

  assign last_iter   = (cnt_q == LAST_STEP);
  assign load_result = (state_d == ST_DONE) && (state_q != ST_DONE);

  always_comb begin
    state_d = state_q;
    s_ready = 1'b0;
    m_valid = 1'b0;
    case (state_q)
      ST_IDLE: begin
        s_ready = 1'b1;
        if (s_valid) state_d = ST_ITER;
      end
      ST_ITER: begin
        if (last_iter) begin
`ifdef CORDIC_GAIN_COMP_EN
          state_d = ST_SCALE;
`else
          state_d = ST_DONE;
`endif
        end
      end
      ST_SCALE: state_d = ST_DONE;
      ST_DONE: begin
        m_valid = 1'b1;
        if (m_ready) state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_comb begin
    x_d    = x_q;
    y_d    = y_q;
    z_d    = z_q;
    cnt_d  = cnt_q;
    zero_d = zero_q;
    mag_d  = mag_q;
    ang_d  = ang_q;
    if (state_q == ST_IDLE && s_valid) begin
      // Pre-rotate by +/-90 degrees so the iterations start in the right half-plane.
      zero_d = (x_i == '0) && (y_i == '0);
      cnt_d  = '0;
      if (!x_ext[XW-1]) begin
        x_d = x_ext;
        y_d = y_ext;
        z_d = '0;
      end else if (!y_ext[XW-1]) begin
        x_d = y_ext;
        y_d = -x_ext;
        z_d = ANGLE_90;
      end else begin
        x_d = -y_ext;
        y_d = x_ext;
        z_d = ANGLE_M90;
      end
    end else if (state_q == ST_ITER) begin
      x_d   = x_step;
      y_d   = y_step;
      z_d   = z_step;
      cnt_d = cnt_q + 5'd1;
    end
    // A zero vector has no defined angle; report exactly zero for both.
    if (load_result) begin
      mag_d = zero_q ? '0 : mag_src;
      ang_d = zero_q ? '0 : ang_src;
    end
  end

  always_ff @(posedge aclk or negedge aresetn) begin
    if (!aresetn) begin
      state_q <= ST_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  always_ff @(posedge aclk or negedge aresetn) begin
    if (!aresetn) begin
      x_q    <= '0;
      y_q    <= '0;
      z_q    <= '0;
      cnt_q  <= '0;
      zero_q <= 1'b0;
      mag_q  <= '0;
      ang_q  <= '0;
    end else begin
      x_q    <= x_d;
      y_q    <= y_d;
      z_q    <= z_d;
      cnt_q  <= cnt_d;
      zero_q <= zero_d;
      mag_q  <= mag_d;
      ang_q  <= ang_d;
    end
  end

  assign mag_o = mag_q;
  assign z_o   = ang_q;

endmodule

// File: tb/tb_cordic_vector_iter.sv
// tb/tb_cordic_vector_iter.sv - self-checking bench for cordic_vector_iter
module tb_cordic_vector_iter;

  localparam int W    = 16;
  localparam int ITER = 16;
`ifdef CORDIC_GAIN_COMP_EN
  localparam int LAT     = ITER + 2;
  localparam int M_1000  = 1000;
  localparam int M_1414  = 1414;
  localparam int M_46341 = 46341;
  localparam int M_32767 = 32767;
`else
  localparam int LAT     = ITER + 1;
  localparam int M_1000  = 1647;
  localparam int M_1414  = 2329;
  localparam int M_46341 = 76313;
  localparam int M_32767 = 53959;
`endif
  localparam int MTOL = 8;
  localparam int ATOL = 32'h0040_0000;

  logic          aclk;
  logic          aresetn;
  logic          s_valid;
  logic          s_ready;
  logic [W-1:0]  x_i;
  logic [W-1:0]  y_i;
  logic          m_valid;
  logic          m_ready;
  logic [W:0]    mag_o;
  logic [31:0]   z_o;

  int checks = 0;
  int passed = 0;
  int unsigned lut [32];

  typedef struct {
    int          x;
    int          y;
    int          mag;
    int          mag_tol;
    int unsigned ang;
    int          ang_tol;
  } vec_t;

  vec_t tbl [8];

  cordic_vector_iter #(.DATA_WIDTH(W), .ITERATION_CNT(ITER)) dut (
    .aclk   (aclk),
    .aresetn(aresetn),
    .s_valid(s_valid),
    .s_ready(s_ready),
    .x_i    (x_i),
    .y_i    (y_i),
    .m_valid(m_valid),
    .m_ready(m_ready),
    .mag_o  (mag_o),
    .z_o    (z_o)
  );

  initial aclk = 1'b0;
  always #5 aclk = ~aclk;

  task automatic check(input string name, input longint act, input longint exp);
    checks++;
    if (act == exp) passed++;
    else $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
  endtask

  task automatic check_tol(input string name, input int act, input int exp, input int tol);
    int d;
    d = act - exp;
    if (d < 0) d = -d;
    checks++;
    if (d <= tol) passed++;
    else $display("FAIL %s: got %0d, expected %0d +/- %0d", name, act, exp, tol);
  endtask

  task automatic check_ang(input string name, input int unsigned act, input int unsigned exp, input int tol);
    int d;
    d = int'(act - exp);
    if (d < 0) d = -d;
    checks++;
    if (d <= tol) passed++;
    else $display("FAIL %s: got 0x%08h, expected 0x%08h +/- 0x%0h", name, act, exp, tol);
  endtask

  // floor(v / 2^s)
  function automatic longint fshift(input longint v, input int s);
    longint p;
    p = longint'(1) << s;
    if (v >= 0) return v / p;
    return -((-v + p - 1) / p);
  endfunction

  // Vectoring CORDIC worked out with plain integer arithmetic.
  function automatic void model(input int xi, input int yi, output int unsigned mag, output int unsigned ang);
    longint x, y, xt;
    int unsigned z;
    if (xi >= 0) begin
      x = xi; y = yi; z = 32'h0;
    end else if (yi >= 0) begin
      x = yi; y = -xi; z = 32'h4000_0000;
    end else begin
      x = -yi; y = xi; z = 32'hC000_0000;
    end
    for (int i = 0; i < ITER; i++) begin
      xt = x;
      if (y >= 0) begin
        x = x + fshift(y, i); y = y - fshift(xt, i); z = z + lut[i];
      end else begin
        x = x - fshift(y, i); y = y + fshift(xt, i); z = z - lut[i];
      end
    end
`ifdef CORDIC_GAIN_COMP_EN
    x = fshift(x * 19898 + 16384, 15);
`endif
    if (xi == 0 && yi == 0) begin
      mag = 0; ang = 0;
    end else begin
      mag = 32'(x & 64'h1FFFF); ang = z;
    end
  endfunction

  task automatic send(input int x, input int y);
    @(negedge aclk);
    check("s_ready_idle", s_ready, 1);
    x_i = x[W-1:0];
    y_i = y[W-1:0];
    s_valid = 1'b1;
    @(negedge aclk);
    s_valid = 1'b0;
    x_i = 16'($urandom);
    y_i = 16'($urandom);
  endtask

  // Rising edges from the accept edge through the one that raises m_valid.
  task automatic wait_result(output int lat);
    lat = 1;
    while (!m_valid && lat < 200) begin
      @(negedge aclk);
      lat++;
    end
  endtask

  task automatic run_vec(input int x, input int y, output int unsigned mag, output int unsigned ang);
    int lat;
    int unsigned em, ea;
    send(x, y);
    wait_result(lat);
    check("latency", lat, LAT);
    mag = mag_o;
    ang = z_o;
    model(x, y, em, ea);
    check("mag_model", mag, em);
    check("ang_model", ang, ea);
    @(negedge aclk);
    check("m_valid_clear", m_valid, 0);
    check("mag_retained", mag_o, mag);
    check("ang_retained", z_o, ang);
  endtask

  initial begin
    int unsigned mag, ang, em, ea, hold_mag, hold_ang;
    int lat, seen;

    for (int i = 0; i < 32; i++)
      lut[i] = $rtoi($atan(2.0 ** (-i)) * 4294967296.0 / (2.0 * 3.14159265358979323846) + 0.5);

    tbl[0] = '{1000,   0,      M_1000,  MTOL, 32'h0000_0000, ATOL};
    tbl[1] = '{0,      1000,   M_1000,  MTOL, 32'h4000_0000, ATOL};
    tbl[2] = '{0,      -1000,  M_1000,  MTOL, 32'hC000_0000, ATOL};
    tbl[3] = '{-1000,  0,      M_1000,  MTOL, 32'h8000_0000, ATOL};
    tbl[4] = '{1000,   1000,   M_1414,  MTOL, 32'h2000_0000, ATOL};
    tbl[5] = '{-32768, -32768, M_46341, MTOL, 32'hA000_0000, ATOL};
    tbl[6] = '{0,      0,      0,       0,    32'h0000_0000, 0};
    tbl[7] = '{32767,  0,      M_32767, MTOL, 32'h0000_0000, ATOL};

    aresetn = 1'b0;
    s_valid = 1'b0;
    m_ready = 1'b1;
    x_i = '0;
    y_i = '0;
    repeat (2) @(negedge aclk);
    check("rst_s_ready", s_ready, 1);
    check("rst_m_valid", m_valid, 0);
    check("rst_mag", mag_o, 0);
    check("rst_z", z_o, 0);
    aresetn = 1'b1;

    for (int t = 0; t < 8; t++) begin
      run_vec(tbl[t].x, tbl[t].y, mag, ang);
      check_tol($sformatf("tbl%0d_mag", t), int'(mag), tbl[t].mag, tbl[t].mag_tol);
      check_ang($sformatf("tbl%0d_ang", t), ang, tbl[t].ang, tbl[t].ang_tol);
    end

    for (int t = 0; t < 40; t++)
      run_vec(int'($urandom_range(65535)) - 32768, int'($urandom_range(65535)) - 32768, mag, ang);

    // Back-pressure in DONE: outputs hold and input pulses are dropped.
    m_ready = 1'b0;
    send(1234, -567);
    wait_result(lat);
    check("bp_latency", lat, LAT);
    hold_mag = mag_o;
    hold_ang = z_o;
    model(1234, -567, em, ea);
    check("bp_mag_model", hold_mag, em);
    check("bp_ang_model", hold_ang, ea);
    for (int k = 0; k < 5; k++) begin
      s_valid = (k % 2 == 0);
      x_i = 16'($urandom);
      y_i = 16'($urandom);
      @(negedge aclk);
      check("bp_m_valid", m_valid, 1);
      check("bp_s_ready", s_ready, 0);
      check("bp_mag_hold", mag_o, hold_mag);
      check("bp_ang_hold", z_o, hold_ang);
    end
    s_valid = 1'b0;
    m_ready = 1'b1;
    @(negedge aclk);
    check("bp_release", m_valid, 0);
    run_vec(-3000, 2500, mag, ang);

    // Reset in the middle of the iterations aborts the vector.
    send(-20000, 15000);
    repeat (5) @(negedge aclk);
    aresetn = 1'b0;
    @(negedge aclk);
    check("abort_m_valid", m_valid, 0);
    check("abort_s_ready", s_ready, 1);
    check("abort_mag", mag_o, 0);
    check("abort_z", z_o, 0);
    aresetn = 1'b1;
    seen = 0;
    repeat (LAT + 4) begin
      @(negedge aclk);
      if (m_valid) seen++;
    end
    check("abort_no_result", seen, 0);
    run_vec(-20000, 15000, mag, ang);

    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end

endmodule
